// File: rtl/aes_dec_pkg.sv
// Shared AES decryption definitions: state byte layout, sequencer FSM states and
// the legal lane-count check used by the InvSubBytes sequencer.
package aes_dec_pkg;

    localparam int unsigned ByteW    = 8;
    localparam int unsigned NumBytes = 16;
    localparam int unsigned StateW   = ByteW * NumBytes;

    // Element NumBytes-1 holds state byte 0 (bits [127:120]).
    typedef logic [NumBytes-1:0][ByteW-1:0] state_t;
    typedef logic [$clog2(NumBytes)-1:0] slot_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } seq_state_e;

    function automatic slot_t byte_slot(input int unsigned k);
        return slot_t'(NumBytes - 1 - k);
    endfunction

    function automatic bit lanes_legal(input int unsigned lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) || (lanes == 16);
    endfunction

endpackage

// File: rtl/Inverse_SBox.sv
// Combinational AES inverse S-box lookup (addr -> dout).
module Inverse_SBox (
    input  logic [7:0] addr,
    output logic [7:0] dout
);

    // Entry for address a sits at element 255-a (= ~a), so each row reads left to right.
    localparam logic [255:0][7:0] InvSbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign dout = InvSbox[~addr];

endmodule

// File: rtl/inv_subbytes_seq.sv
// InvSubBytes sequencer: time-shares LANES inverse S-boxes over 16/LANES steps per state.
// Define INV_SUBBYTES_PIPE_EN to register the lookup outputs (adds one drain cycle).
module inv_subbytes_seq
    import aes_dec_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [StateW-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [StateW-1:0] out_data,
    output logic              busy
);

    localparam int unsigned STEPS = NumBytes / LANES;
    localparam int unsigned CntW  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(STEPS - 1);

    if (!lanes_legal(LANES)) begin : g_lanes_check
        $error("inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    seq_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    state_t          work_q, work_d;
    logic [ByteW-1:0] lut_addr [LANES];
    logic [ByteW-1:0] lut_dout [LANES];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lut_addr[i] = work_q[byte_slot(32'(cnt_q) * LANES + 32'(i))];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        Inverse_SBox u_sbox (
            .addr(lut_addr[g]),
            .dout(lut_dout[g])
        );
    end

`ifdef INV_SUBBYTES_PIPE_EN
    logic [ByteW-1:0] lut_q [LANES];
    logic             wb_pend_q, wb_pend_d;
    logic [CntW-1:0]  wb_cnt_q, wb_cnt_d;

    always_ff @(posedge clk) begin
        lut_q <= lut_dout;
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        out_valid = 1'b0;
        in_ready  = (state_q == StIdle) && !reset;
`ifdef INV_SUBBYTES_PIPE_EN
        wb_pend_d = 1'b0;
        wb_cnt_d  = wb_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    work_d  = in_data;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
`ifdef INV_SUBBYTES_PIPE_EN
                // Write-back trails the lookup by one cycle; slots never overlap.
                if (wb_pend_q) begin
                    for (int i = 0; i < LANES; i++) begin
                        work_d[byte_slot(32'(wb_cnt_q) * LANES + 32'(i))] = lut_q[i];
                    end
                end
                if (wb_pend_q && (wb_cnt_q == CntLast)) begin
                    state_d = StDone;
                end else begin
                    wb_pend_d = 1'b1;
                    wb_cnt_d  = cnt_q;
                    cnt_d     = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
                end
`else
                for (int i = 0; i < LANES; i++) begin
                    work_d[byte_slot(32'(cnt_q) * LANES + 32'(i))] = lut_dout[i];
                end
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            work_q  <= '0;
`ifdef INV_SUBBYTES_PIPE_EN
            wb_pend_q <= 1'b0;
            wb_cnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
`ifdef INV_SUBBYTES_PIPE_EN
            wb_pend_q <= wb_pend_d;
            wb_cnt_q  <= wb_cnt_d;
`endif
        end
    end

    assign out_data = work_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Self-checking bench for inv_subbytes_seq; reference inverse S-box derived from GF(2^8) math.
module tb_inv_subbytes_seq;

    localparam int unsigned MainLanes = 4;
`ifdef INV_SUBBYTES_PIPE_EN
    localparam int PipeLat = 1;
`else
    localparam int PipeLat = 0;
`endif
    localparam int MainLat = 16 / MainLanes + PipeLat;
    localparam int WideLat = 1 + PipeLat;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         busy;

    logic         w_valid = 1'b0;
    logic         w_ready;
    logic [127:0] w_data = '0;
    logic         w_out_valid;
    logic [127:0] w_out_data;
    logic         w_busy;

    inv_subbytes_seq #(.LANES(MainLanes)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    inv_subbytes_seq #(.LANES(16)) dut_wide (
        .clk(clk), .reset(reset), .in_valid(w_valid), .in_ready(w_ready), .in_data(w_data),
        .out_valid(w_out_valid), .out_ready(1'b1), .out_data(w_out_data), .busy(w_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: inverse affine transform followed by GF(2^8) inversion.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int x = 1; x < 256; x++) begin
            if (gmul(a, 8'(x)) == 8'h01) return 8'(x);
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    logic [7:0] inv_tbl [256];

    function automatic logic [127:0] model_state(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tbl[s[8*k +: 8]];
        return r;
    endfunction

    // Cycle-level expectation for the main instance.
    logic         model_on = 1'b0;
    logic         inflight = 1'b0;
    logic         zero_out = 1'b0;
    int           acc_edge = 0;
    logic [127:0] exp_data = '0;
    logic         exp_ov;
    assign exp_ov = inflight && (cyc - acc_edge >= MainLat);

    always @(negedge clk) begin
        if (reset) begin
            if (model_on) chk("in_ready_during_reset", 128'(in_ready), 128'(0));
            model_on <= 1'b1;
            inflight <= 1'b0;
            zero_out <= 1'b1;
        end else if (model_on) begin
            chk("in_ready", 128'(in_ready), 128'(!inflight));
            chk("busy", 128'(busy), 128'(inflight));
            chk("out_valid", 128'(out_valid), 128'(exp_ov));
            if (exp_ov) chk("out_data", out_data, exp_data);
            else if (zero_out) chk("out_data_after_reset", out_data, 128'h0);
            if (exp_ov && out_ready) begin
                inflight <= 1'b0;
            end else if (!inflight && in_valid) begin
                inflight <= 1'b1;
                acc_edge <= cyc + 1;
                exp_data <= model_state(in_data);
                zero_out <= 1'b0;
            end
        end
    end

    task automatic send(input logic [127:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic expect_out(input logic [127:0] exp, input string name, input int stall);
        int n = 0;
        out_ready = (stall == 0);
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, 128'(out_valid), 128'(1));
        chk(name, out_data, exp);
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            chk({name, "_held"}, out_data, exp);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_wide(input logic [127:0] s);
        int e = 0;
        w_valid = 1'b1;
        w_data  = s;
        @(negedge clk);
        while (!w_ready && e < 50) begin
            @(negedge clk);
            e++;
        end
        chk("wide_accept", 128'(w_ready), 128'(1));
        @(posedge clk);
        #1;
        w_valid = 1'b0;
        w_data  = {$urandom, $urandom, $urandom, $urandom};
        e = 0;
        @(negedge clk);
        while (!w_out_valid && e < 50) begin
            @(negedge clk);
            e++;
        end
        chk("wide_latency", 128'(e), 128'(WideLat));
        chk("wide_data", w_out_data, model_state(s));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] sweep_state(input int j);
        logic [127:0] s;
        for (int k = 0; k < 16; k++) s[127 - 8*k -: 8] = 8'(16 * j + k);
        return s;
    endfunction

    initial begin
        for (int v = 0; v < 256; v++) begin
            inv_tbl[v] = ginv(rotl(8'(v), 1) ^ rotl(8'(v), 3) ^ rotl(8'(v), 6) ^ 8'h05);
        end
        chk("model_63", 128'(inv_tbl[8'h63]), 128'h00);
        chk("model_00", 128'(inv_tbl[8'h00]), 128'h52);
        chk("model_ff", 128'(inv_tbl[8'hff]), 128'h7d);
        chk("model_7c", 128'(inv_tbl[8'h7c]), 128'h01);
        chk("model_52", 128'(inv_tbl[8'h52]), 128'h48);
        chk("model_01", 128'(inv_tbl[8'h01]), 128'h09);
        chk("model_0f", 128'(inv_tbl[8'h0f]), 128'hfb);

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        send({16{8'h63}});
        expect_out(128'h0, "all_63", 0);
        send(128'h000102030405060708090a0b0c0d0e0f);
        expect_out(128'h52096ad53036a538bf40a39e81f3d7fb, "ramp", 0);
        send({16{8'hff}});
        expect_out({16{8'h7d}}, "backpressure", 10);

        // Second state offered while the first is still in flight.
        send({16{8'h7c}});
        in_valid = 1'b1;
        in_data  = {16{8'h52}};
        expect_out({16{8'h01}}, "b2b_first", 0);
        send({16{8'h52}});
        expect_out({16{8'h48}}, "b2b_second", 0);

        send({16{8'hc3}});
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        send({16{8'h01}});
        expect_out({16{8'h09}}, "after_abort", 0);

        for (int j = 0; j < 16; j++) begin
            send(sweep_state(j));
            expect_out(model_state(sweep_state(j)), "sweep", (j % 3 == 1) ? 3 : 0);
        end
        for (int j = 0; j < 16; j++) run_wide(sweep_state(j));

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/inv_subbytes_seq.md
Name: inv_subbytes_seq

Overview:
- Sequencer for the inverse S-box lookup. Performs InvSubBytes on a full 128-bit AES state by time-sharing LANES lookup instances over 16/LANES steps.
- Sits in the decryption round datapath between InvShiftRows and AddRoundKey.
- Valid/ready handshake on both sides; one state in flight at a time.

Parameters:
- LANES, 4, number of inverse S-box instances / bytes processed per step; legal values 1, 2, 4, 8, 16.
- STEPS, 16/LANES, derived localparam; number of lookup steps per state.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input state valid.
- in_ready  out  1  block can accept a state.
- in_data  in  128  input state; byte 0 = [127:120] … byte 15 = [7:0].
- out_valid  out  1  result state valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  128  InvSubBytes(in_data), same byte order.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset values: in_ready=0 during reset, 1 on the first cycle after it. out_valid=0, out_data=0, busy=0, step counter=0, FSM=IDLE.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_data into the work register, clear the counter, go to RUN.
  - RUN: in_ready=0. Each cycle, bytes [cnt*LANES .. cnt*LANES+LANES-1] of the work register go through the LANES lookups, and the results overwrite the same byte slots. cnt increments. When cnt==STEPS-1, go to DONE.
  - DONE: out_valid=1, out_data=work register, held stable until out_valid&&out_ready. On that handshake, go to IDLE.
- Latency: accept at edge T; out_valid first visible after edge T+STEPS (4 cycles at LANES=4, 1 cycle at LANES=16). Throughput is one state per STEPS+2 cycles with out_ready tied high.
- No overlap: in_ready stays 0 in RUN and DONE. A new accept is possible only in the cycle after the output handshake.
- in_data is sampled only at accept. Later changes to in_data are ignored.
- Backpressure: while out_ready=0 in DONE, out_data and out_valid do not change.
- in_valid asserted in RUN or DONE is not accepted. The upstream holds it; no loss.
- LANES=16: RUN lasts exactly one cycle (cnt==0==STEPS-1).
- cnt width is clog2(STEPS), minimum 1 bit. It is never compared beyond STEPS-1.
- reset asserted in RUN or DONE: abort immediately, all outputs return to reset values, and the partial result is discarded.
- An illegal LANES value is an elaboration-time error (generate-time check).

Optional Feature:
- Macro INV_SUBBYTES_PIPE_EN.
- Defined: a register is inserted on the LANES lookup outputs. RUN gains a drain cycle: write-back lags the lookup by one cycle, and the last write-back happens on the cycle after cnt==STEPS-1. Latency becomes STEPS+1. All other handshake rules are unchanged.
- Undefined: purely combinational lookup-to-write-back path as described above.

Decomposition:
- Shared package aes_dec_pkg holds:
  - state-byte index constants;
  - the FSM state enum (IDLE, RUN, DONE);
  - the legal-LANES check function.
- Sub-module: the existing combinational Inverse_SBox lookup (addr→dout), instantiated LANES times in a generate loop. No other sub-module is needed.

Test Plan:
- Reset then in_data=16×8'h63, LANES=4, out_ready=1 -> out_data=128'h0, out_valid rises 4 cycles after accept, busy high for cycles 1–5.
- in_data=00 01 02 … 0f -> out_data=52 09 6a d5 30 36 a5 38 bf 40 a3 9e 81 f3 d7 fb.
- in_data=16×8'hff with out_ready=0 for 10 cycles -> out_data=16×8'h7d held stable, in_ready=0 throughout; then out_ready=1 -> in_ready=1 on the next cycle.
- Back-to-back: in_valid held high with two states (7c…, 52…) -> second accepted only after the first output handshake; bytes 7c→01 and 52→48 are correct.
- reset pulsed at RUN step 2 -> out_valid=0, out_data=0, busy=0 next cycle; a following state 16×8'h01 -> 16×8'h09 with no residue.
- Sweep LANES=1/16 and INV_SUBBYTES_PIPE_EN on/off, all 256 byte values -> matches the reference table; latency = STEPS (+1 with the macro).
